tl_ul_sram_responder: RTL and testbench
=======================================

// Module: tl_ul_sram_responder
// PURPOSE
//  TL-UL manager (responder) end of the 32-bit peripheral link whose A-channel traffic the protocol monitors check.
//  Accepts single-beat Get/PutFullData/PutPartialData on channel A and returns AccessAckData/AccessAck on channel D.
//  Backed by a word-wide synchronous RAM; responses are buffered so accept throughput is 1 req/cycle under no backpressure.
// PARAMETERS
//  BASE_ADDR   26'h000_0000  first byte address decoded by this manager
//  DEPTH_WORDS 256           RAM depth in 32-bit words (power of 2, 2..4096)
//  RSP_DEPTH   2             response queue entries (>=2)
// PORTS
//  clock       in   1   sole clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  a_valid     in   1   A request valid
//  a_ready     out  1   A request accepted when a_valid&a_ready
//  a_opcode    in   3   0 PutFullData, 1 PutPartialData, 4 Get; others unsupported
//  a_param     in   3   must be 0
//  a_size      in   3   log2 bytes, legal 0..2
//  a_source    in   5   requester id, echoed on d_source
//  a_address   in   26  byte address
//  a_mask      in   4   byte lanes
//  a_data      in   32  write data
//  a_corrupt   in   1   write data poisoned
//  d_valid     out  1   D response valid
//  d_ready     in   1   D response consumed when d_valid&d_ready
//  d_opcode    out  3   0 AccessAck, 1 AccessAckData
//  d_param     out  2   always 0
//  d_size      out  3   echo of a_size
//  d_source    out  5   echo of a_source
//  d_sink      out  1   always 0
//  d_denied    out  1   request rejected
//  d_data      out  32  read data (0 when not AccessAckData or denied)
//  d_corrupt   out  1   data invalid
// BEHAVIOUR
//  Reset: a_ready=0 during reset, d_valid=0, all d_* fields 0, queue empty, inflight=0. RAM contents not reset.
//  Credits: a_ready = !reset && (q_count + inflight) < RSP_DEPTH; a_ready independent of a_valid.
//  Accept cycle N: decode, write RAM at edge N (if legal Put), read RAM addr issued at edge N (if legal Get); inflight=1.
//  Cycle N+1: response (with RAM rdata for Get) pushed into queue; d_valid earliest in N+1 (1-cycle latency).
//  Pop and push same cycle allowed; full queue with d_ready=1 frees a credit the next cycle, not combinationally.
//  Decode: off = a_address - BASE_ADDR; legal iff off < DEPTH_WORDS*4, a_param==0, a_size<=2,
//   address aligned to 2^a_size, a_mask only inside aligned size window, opcode in {0,1,4},
//   PutFull additionally requires a_mask == full window for a_size.
//  Illegal: no RAM write; d_denied=1; Get -> AccessAckData, d_data=0, d_corrupt=1; Put -> AccessAck, d_corrupt=0.
//   Unsupported opcodes answer AccessAck denied.
//  Legal Put: byte-enable write per a_mask; a_corrupt=1 suppresses write, ack AccessAck, d_denied=0.
//  Legal Get: d_data = full RAM word (all lanes), d_corrupt=0, d_denied=0.
//  Ordering: responses strictly in accept order; Get accepted the cycle after a Put to same word returns new data.
//  d_* fields held stable while d_valid && !d_ready.
//  Reset mid-operation: queue and inflight flushed; pending responses dropped; no RAM write on reset cycle.
// STRUCTURE
//  tl_ul_pkg: opcode constants (PUT_FULL, PUT_PARTIAL, GET, ACCESS_ACK, ACCESS_ACK_DATA), d-response struct typedef.
//  Sub-module tl_ul_rsp_queue: RSP_DEPTH-entry FIFO of response structs, sync reset, count output.
//  Top: decode, credit logic, byte-enable RAM array, inflight register.
// TESTING
//  1 PutFull addr BASE+0x10 data 32'hDEADBEEF mask f, then Get same -> AccessAck then AccessAckData 32'hDEADBEEF, source echoed.
//  2 PutPartial mask 4'b0100 data 32'h00AA0000 over 32'h11223344 -> Get returns 32'h11AA3344.
//  3 Get addr BASE+DEPTH_WORDS*4 -> d_denied=1, d_corrupt=1, d_data=0; Get size=1 addr 0x1 -> denied.
//  4 d_ready=0 with back-to-back Gets -> exactly RSP_DEPTH accepts then a_ready=0; release -> in-order drain.
//  5 back-to-back Put/Get same word, d_ready=1 -> one accept per cycle, Get sees new data, 1-cycle latency.
//  6 reset asserted with 2 queued responses -> d_valid=0 next cycle, a_ready=0 until reset deasserts.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: TL-UL opcode constants and the D-channel response record shared by the responder.
package tl_ul_pkg;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [4:0]  source;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } d_rsp_t;
endpackage

// File: rtl/tl_ul_rsp_queue.sv
// tl_ul_rsp_queue: circular FIFO of D-channel responses with occupancy count.
module tl_ul_rsp_queue
  import tl_ul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  d_rsp_t        wdata,
  input  logic          pop,
  output d_rsp_t        rdata,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  d_rsp_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign rdata = mem[rp];
  always_ff @(posedge clock)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/tl_ul_sram_responder.sv
// tl_ul_sram_responder: TL-UL manager serving single-beat Get/Put from a byte-enable word RAM.
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter logic [25:0] BASE_ADDR   = 26'h000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          RSP_DEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [4:0]  a_source,
  input  logic [25:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  input  logic        a_corrupt,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [4:0]  d_source,
  output logic        d_sink,
  output logic        d_denied,
  output logic [31:0] d_data,
  output logic        d_corrupt
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic [25:0] off;
  logic [AW-1:0] idx;
  logic [3:0] win;
  logic aligned, is_get, is_put, legal, accept, we;
  logic inflight, inf_rd;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata;
  d_rsp_t inf_rsp, rsp, head, out;
  logic [CW-1:0] q_count;
  logic push, pop;
  assign off     = a_address - BASE_ADDR;
  assign idx     = off[AW+1:2];
  assign is_get  = a_opcode == GET;
  assign is_put  = a_opcode == PUT_FULL || a_opcode == PUT_PARTIAL;
  assign win     = a_size == 3'd0 ? 4'b0001 << off[1:0] : a_size == 3'd1 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  assign aligned = a_size == 3'd0 || (a_size == 3'd1 && !off[0]) || (a_size == 3'd2 && off[1:0] == 2'd0);
  assign legal   = (is_get || is_put) && off < 26'(DEPTH_WORDS * 4) && a_param == 3'd0 && aligned
                   && (a_mask & ~win) == 4'd0 && (a_opcode != PUT_FULL || a_mask == win);
  // Credits count both queued and in-flight responses so the queue can never overflow.
  assign a_ready = !reset && (32'(q_count) + 32'(inflight)) < RSP_DEPTH;
  assign accept  = a_valid && a_ready;
  assign we      = accept && legal && is_put && !a_corrupt;
  always_ff @(posedge clock) begin
    if (accept) rdata <= mem[idx];
    for (int i = 0; i < 4; i++)
      if (we && a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;
      inf_rd   <= 1'b0;
      inf_rsp  <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inf_rd  <= is_get && legal;
        inf_rsp <= '{opcode: is_get ? ACCESS_ACK_DATA : ACCESS_ACK, size: a_size, source: a_source,
                     denied: !legal, corrupt: is_get && !legal, data: '0};
      end
    end
  end
  always_comb begin
    rsp      = inf_rsp;
    rsp.data = inf_rd ? rdata : '0;
  end
  // The in-flight response bypasses an empty queue, giving one-cycle latency.
  assign pop  = q_count != '0 && d_ready;
  assign push = inflight && !(q_count == '0 && d_ready);
  tl_ul_rsp_queue #(.DEPTH(RSP_DEPTH), .CW(CW)) u_queue (
    .clock(clock),
    .reset(reset),
    .push (push),
    .wdata(rsp),
    .pop  (pop),
    .rdata(head),
    .count(q_count)
  );
  assign d_valid   = !reset && (q_count != '0 || inflight);
  assign out       = !d_valid ? '0 : q_count != '0 ? head : rsp;
  assign d_opcode  = out.opcode;
  assign d_param   = '0;
  assign d_size    = out.size;
  assign d_source  = out.source;
  assign d_sink    = 1'b0;
  assign d_denied  = out.denied;
  assign d_data    = out.data;
  assign d_corrupt = out.corrupt;
endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// tb_tl_ul_sram_responder: scoreboard bench driving TL-UL requests and checking D responses in order.
module tb_tl_ul_sram_responder;
  import tl_ul_pkg::*;
  localparam logic [25:0] BASE = 26'h000_1000;
  localparam int DW = 256;
  localparam int RD = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic a_valid = 1'b0, a_ready, a_corrupt = 1'b0;
  logic [2:0] a_opcode = '0, a_param = '0, a_size = '0;
  logic [4:0] a_source = '0;
  logic [25:0] a_address = '0;
  logic [3:0] a_mask = '0;
  logic [31:0] a_data = '0;
  logic d_valid, d_ready = 1'b1, d_sink, d_denied, d_corrupt;
  logic [2:0] d_opcode, d_size;
  logic [1:0] d_param;
  logic [4:0] d_source;
  logic [31:0] d_data;
  logic [47:0] d_vec;
  typedef struct {
    logic [47:0] rsp;
    bit          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int errors = 0, checks = 0, cyc = 0, last_acc = 0;
  bit rnd_on = 1'b0;
  logic [31:0] ref_mem [8];
  tl_ul_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DW), .RSP_DEPTH(RD)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt)
  );
  assign d_vec = {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data};
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (rnd_on) begin #1 d_ready = 1'($urandom_range(0, 1)); end
  initial begin #200000; $display("FAIL global_timeout: simulation exceeded time limit"); $fatal; end
  function automatic logic [47:0] rsp(logic [2:0] op, logic [2:0] sz, logic [4:0] src, logic den, logic cor, logic [31:0] dat);
    return {op, 2'b00, sz, src, 1'b0, den, cor, dat};
  endfunction
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clock)
    if (!reset && d_valid && d_ready) begin
      if (sb.size() == 0) check("unexpected_rsp_sb_count", 48'(sb.size()), 48'd1);
      else begin
        mon_e = sb.pop_front();
        check("rsp", d_vec, mon_e.rsp);
        if (mon_e.lat) check("latency", 48'(cyc - mon_e.acc), 48'd1);
      end
    end
  task automatic send(input logic [2:0] op, input logic [25:0] addr, input logic [2:0] sz, input logic [3:0] mask,
                      input logic [31:0] dat, input logic [4:0] src, input logic [47:0] exp, input bit lat = 0,
                      input logic [2:0] par = 3'd0, input logic cor = 1'b0);
    int n = 0;
    int acc = 0;
    bit ok = 0;
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_size = sz; a_mask = mask;
    a_data = dat; a_source = src; a_param = par; a_corrupt = cor;
    while (!ok && n < 200) begin
      @(negedge clock);
      acc = cyc;
      ok = a_ready;
      n++;
    end
    if (!ok) begin
      check("a_ready_timeout", 48'(ok), 48'd1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 a_valid = 1'b0;
    sb.push_back('{exp, lat, acc});
    last_acc = acc;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clock); n++; end
    check("drain_left", 48'(sb.size()), 48'd0);
    @(posedge clock);
    #1;
  endtask
  initial begin
    int a1;
    logic [31:0] d;
    int w;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_a_ready", 48'(a_ready), 48'd0);
    check("reset_d_valid", 48'(d_valid), 48'd0);
    check("reset_d_fields", d_vec, 48'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_reset_a_ready", 48'(a_ready), 48'd1);
    @(posedge clock);
    #1;
    send(PUT_FULL, BASE + 26'h10, 3'd2, 4'hf, 32'hDEADBEEF, 5'd3, rsp(ACCESS_ACK, 3'd2, 5'd3, 0, 0, 0));
    send(GET, BASE + 26'h10, 3'd2, 4'hf, 32'h0, 5'd7, rsp(ACCESS_ACK_DATA, 3'd2, 5'd7, 0, 0, 32'hDEADBEEF));
    send(PUT_FULL, BASE + 26'h20, 3'd2, 4'hf, 32'h11223344, 5'd1, rsp(ACCESS_ACK, 3'd2, 5'd1, 0, 0, 0));
    send(PUT_PARTIAL, BASE + 26'h22, 3'd0, 4'b0100, 32'h00AA0000, 5'd2, rsp(ACCESS_ACK, 3'd0, 5'd2, 0, 0, 0));
    send(GET, BASE + 26'h20, 3'd2, 4'hf, 32'h0, 5'd9, rsp(ACCESS_ACK_DATA, 3'd2, 5'd9, 0, 0, 32'h11AA3344));
    send(GET, BASE + 26'h22, 3'd1, 4'b1100, 32'h0, 5'd10, rsp(ACCESS_ACK_DATA, 3'd1, 5'd10, 0, 0, 32'h11AA3344));
    send(GET, BASE + 26'(DW * 4), 3'd2, 4'hf, 32'h0, 5'd11, rsp(ACCESS_ACK_DATA, 3'd2, 5'd11, 1, 1, 0));
    send(GET, BASE + 26'h1, 3'd1, 4'b0011, 32'h0, 5'd12, rsp(ACCESS_ACK_DATA, 3'd1, 5'd12, 1, 1, 0));
    send(GET, BASE - 26'h4, 3'd2, 4'hf, 32'h0, 5'd13, rsp(ACCESS_ACK_DATA, 3'd2, 5'd13, 1, 1, 0));
    send(GET, BASE + 26'h10, 3'd2, 4'hf, 32'h0, 5'd14, rsp(ACCESS_ACK_DATA, 3'd2, 5'd14, 1, 1, 0), 0, 3'd1);
    send(3'd2, BASE + 26'h10, 3'd2, 4'hf, 32'h0, 5'd15, rsp(ACCESS_ACK, 3'd2, 5'd15, 1, 0, 0));
    send(PUT_FULL, BASE + 26'h10, 3'd2, 4'b0111, 32'h0, 5'd16, rsp(ACCESS_ACK, 3'd2, 5'd16, 1, 0, 0));
    send(PUT_FULL, BASE + 26'h10, 3'd2, 4'hf, 32'h0, 5'd17, rsp(ACCESS_ACK, 3'd2, 5'd17, 0, 0, 0), 0, 3'd0, 1'b1);
    send(GET, BASE + 26'h10, 3'd2, 4'hf, 32'h0, 5'd18, rsp(ACCESS_ACK_DATA, 3'd2, 5'd18, 0, 0, 32'hDEADBEEF));
    drain();
    d_ready = 1'b0;
    send(GET, BASE + 26'h10, 3'd2, 4'hf, 32'h0, 5'd1, rsp(ACCESS_ACK_DATA, 3'd2, 5'd1, 0, 0, 32'hDEADBEEF));
    send(GET, BASE + 26'h20, 3'd2, 4'hf, 32'h0, 5'd2, rsp(ACCESS_ACK_DATA, 3'd2, 5'd2, 0, 0, 32'h11AA3344));
    fork
      send(GET, BASE + 26'h10, 3'd2, 4'hf, 32'h0, 5'd3, rsp(ACCESS_ACK_DATA, 3'd2, 5'd3, 0, 0, 32'hDEADBEEF));
      begin
        repeat (4) begin
          @(negedge clock);
          check("stall_a_ready", 48'(a_ready), 48'd0);
          check("stall_hold", d_vec, rsp(ACCESS_ACK_DATA, 3'd2, 5'd1, 0, 0, 32'hDEADBEEF));
        end
        @(posedge clock);
        #1 d_ready = 1'b1;
      end
    join
    drain();
    send(PUT_FULL, BASE + 26'h40, 3'd2, 4'hf, 32'hCAFEF00D, 5'd4, rsp(ACCESS_ACK, 3'd2, 5'd4, 0, 0, 0), 1);
    a1 = last_acc;
    send(GET, BASE + 26'h40, 3'd2, 4'hf, 32'h0, 5'd5, rsp(ACCESS_ACK_DATA, 3'd2, 5'd5, 0, 0, 32'hCAFEF00D), 1);
    check("b2b_accept_gap", 48'(last_acc - a1), 48'd1);
    drain();
    d_ready = 1'b0;
    send(GET, BASE + 26'h10, 3'd2, 4'hf, 32'h0, 5'd6, rsp(ACCESS_ACK_DATA, 3'd2, 5'd6, 0, 0, 32'hDEADBEEF));
    send(GET, BASE + 26'h20, 3'd2, 4'hf, 32'h0, 5'd7, rsp(ACCESS_ACK_DATA, 3'd2, 5'd7, 0, 0, 32'h11AA3344));
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    check("rst_mid_d_valid", 48'(d_valid), 48'd0);
    check("rst_mid_a_ready", 48'(a_ready), 48'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_flushed_d_valid", 48'(d_valid), 48'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    d_ready = 1'b1;
    @(negedge clock);
    check("rst_release_a_ready", 48'(a_ready), 48'd1);
    check("rst_release_d_valid", 48'(d_valid), 48'd0);
    @(posedge clock);
    #1;
    send(GET, BASE + 26'h40, 3'd2, 4'hf, 32'h0, 5'd8, rsp(ACCESS_ACK_DATA, 3'd2, 5'd8, 0, 0, 32'hCAFEF00D), 1);
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 32'h5A000000 + 32'(i);
      send(PUT_FULL, BASE + 26'(32'h100 + 4 * i), 3'd2, 4'hf, ref_mem[i], 5'(i), rsp(ACCESS_ACK, 3'd2, 5'(i), 0, 0, 0));
    end
    rnd_on = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        ref_mem[w] = d;
        send(PUT_FULL, BASE + 26'(32'h100 + 4 * w), 3'd2, 4'hf, d, 5'(k), rsp(ACCESS_ACK, 3'd2, 5'(k), 0, 0, 0));
      end else
        send(GET, BASE + 26'(32'h100 + 4 * w), 3'd2, 4'hf, 32'h0, 5'(k), rsp(ACCESS_ACK_DATA, 3'd2, 5'(k), 0, 0, ref_mem[w]));
    end
    rnd_on = 1'b0;
    @(posedge clock);
    #2 d_ready = 1'b1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
